// File: rtl/axis_up_shift_pkg.sv
// Shared types for the AXI4-Stream width up-converter.
package axis_up_shift_pkg;

  // FILL: word under construction (out tvalid low); FULL: word presented downstream.
  typedef enum logic {
    UP_FILL = 1'b0,
    UP_FULL = 1'b1
  } up_state_e;

endpackage

// File: rtl/axis_up_shift.sv
// AXI4-Stream up-converter: packs S narrow beats into one wide beat, first beat in lane 0.
// One word register serves as both accumulator and output stage.
module axis_up_shift
  import axis_up_shift_pkg::*;
#(
  parameter int N = 4,
  parameter int S = 4,
  parameter int I = 1,
  parameter int D = 1,
  parameter int U = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             axis_in_tvalid,
  output logic             axis_in_tready,
  input  logic [N*8/S-1:0] axis_in_tdata,
  input  logic             axis_in_tlast,
  input  logic [I-1:0]     axis_in_tid,
  input  logic [D-1:0]     axis_in_tdest,
  input  logic [U-1:0]     axis_in_tuser,
  output logic             axis_out_tvalid,
  input  logic             axis_out_tready,
  output logic [8*N-1:0]   axis_out_tdata,
  output logic [N-1:0]     axis_out_tkeep,
  output logic             axis_out_tlast,
  output logic [I-1:0]     axis_out_tid,
  output logic [D-1:0]     axis_out_tdest,
  output logic [U-1:0]     axis_out_tuser
);

  localparam int N_IN  = N / S;
  localparam int W     = N_IN * 8;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

  if (S < 2) begin : g_bad_s
    $fatal(1, "axis_up_shift: S must be greater than 1");
  end
  if (N % S != 0) begin : g_bad_ns
    $fatal(1, "axis_up_shift: N must be a multiple of S");
  end

  // Handshake: a beat transfers on a rising aclk edge where tvalid & tready are both 1.
  // Sources hold tvalid and payload stable until transfer; axis_in_tready never looks
  // at axis_in_tvalid, so there is no combinational loop through this block.

  up_state_e        state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [8*N-1:0]   tdata_q, tdata_nxt;
  logic [N-1:0]     tkeep_q, tkeep_nxt;
  logic [U-1:0]     tuser_q, tuser_nxt;
  logic             tlast_q;
  logic [I-1:0]     tid_q;
  logic [D-1:0]     tdest_q;
  logic             accept;
  logic             first_beat;
  logic             complete;

  assign axis_out_tvalid = (state == UP_FULL);
  assign axis_in_tready  = ~axis_out_tvalid | axis_out_tready;
  assign accept          = axis_in_tvalid & axis_in_tready;
  assign first_beat      = (idx == '0);
  assign complete        = accept & ((idx == IDX_W'(S - 1)) | axis_in_tlast);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= UP_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UP_FILL: if (complete) state_nxt = UP_FULL;
      UP_FULL: begin
        if (complete) begin
          state_nxt = UP_FULL;
        end else if (axis_out_tready) begin
          state_nxt = UP_FILL;
        end
      end
      default: state_nxt = UP_FILL;
    endcase
  end

  // A first beat starts from a clean word so short packets leave unused lanes zero.
  always_comb begin
    tdata_nxt = first_beat ? '0 : tdata_q;
    tkeep_nxt = first_beat ? '0 : tkeep_q;
    tuser_nxt = first_beat ? '0 : tuser_q;
    for (int l = 0; l < S; l++) begin
      if (idx == IDX_W'(l)) begin
        tdata_nxt[l*W +: W]       = axis_in_tdata;
        tkeep_nxt[l*N_IN +: N_IN] = '1;
      end
    end
    tuser_nxt = tuser_nxt | axis_in_tuser;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      idx     <= '0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      tid_q   <= '0;
      tdest_q <= '0;
    end else if (accept) begin
      tdata_q <= tdata_nxt;
      tkeep_q <= tkeep_nxt;
      tuser_q <= tuser_nxt;
      if (first_beat) begin
        tid_q   <= axis_in_tid;
        tdest_q <= axis_in_tdest;
      end
      if (complete) begin
        tlast_q <= axis_in_tlast;
        idx     <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign axis_out_tdata = tdata_q;
  assign axis_out_tkeep = tkeep_q;
  assign axis_out_tlast = tlast_q;
  assign axis_out_tid   = tid_q;
  assign axis_out_tdest = tdest_q;
  assign axis_out_tuser = tuser_q;

endmodule

// File: tb/tb_axis_up_shift.sv
// Self-checking bench for axis_up_shift: packet-level model feeds an expected queue,
// a monitor pops and compares on every output handshake.
module tb_axis_up_shift;

  localparam int N    = 4;
  localparam int S    = 4;
  localparam int I    = 4;
  localparam int D    = 2;
  localparam int U    = 1;
  localparam int N_IN = N / S;
  localparam int W    = N_IN * 8;
  localparam int EW   = 1 + I + D + U + N + 8 * N;

  logic           aclk;
  logic           areset;
  logic           axis_in_tvalid;
  logic           axis_in_tready;
  logic [W-1:0]   axis_in_tdata;
  logic           axis_in_tlast;
  logic [I-1:0]   axis_in_tid;
  logic [D-1:0]   axis_in_tdest;
  logic [U-1:0]   axis_in_tuser;
  logic           axis_out_tvalid;
  logic           axis_out_tready;
  logic [8*N-1:0] axis_out_tdata;
  logic [N-1:0]   axis_out_tkeep;
  logic           axis_out_tlast;
  logic [I-1:0]   axis_out_tid;
  logic [D-1:0]   axis_out_tdest;
  logic [U-1:0]   axis_out_tuser;

  axis_up_shift #(.N(N), .S(S), .I(I), .D(D), .U(U)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tlast   (axis_in_tlast),
    .axis_in_tid     (axis_in_tid),
    .axis_in_tdest   (axis_in_tdest),
    .axis_in_tuser   (axis_in_tuser),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tid    (axis_out_tid),
    .axis_out_tdest  (axis_out_tdest),
    .axis_out_tuser  (axis_out_tuser)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  pk_beats[$];
  logic [I-1:0]  pk_id;
  logic [D-1:0]  pk_dest;
  logic [U-1:0]  pk_user;
  int            n_chk  = 0;
  int            n_fail = 0;
  int            ready_pct = 100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level reference: collect beats, emit one word per S beats or at tlast.
  function automatic void model_accept(input logic [W-1:0] data, input logic last,
                                       input logic [I-1:0] id, input logic [D-1:0] dest,
                                       input logic [U-1:0] user);
    logic [8*N-1:0] d;
    logic [N-1:0]   k;
    logic [N-1:0]   lane_ones;
    if (pk_beats.size() == 0) begin
      pk_id   = id;
      pk_dest = dest;
      pk_user = '0;
    end
    pk_beats.push_back(data);
    pk_user = pk_user | user;
    if (pk_beats.size() == S || last) begin
      d = '0;
      k = '0;
      lane_ones = N'({N_IN{1'b1}});
      foreach (pk_beats[b]) begin
        d = d | ((8*N)'(pk_beats[b]) << (b * W));
        k = k | (lane_ones << (b * N_IN));
      end
      exp_q.push_back({last, pk_id, pk_dest, pk_user, k, d});
      pk_beats.delete();
    end
  endfunction

  // ---------------- downstream ready generator ----------------
  initial begin
    axis_out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      axis_out_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // ---------------- monitor ----------------
  logic          hold = 1'b0;
  logic [EW-1:0] held;
  initial begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    forever begin
      @(negedge aclk);
      cur = {axis_out_tlast, axis_out_tid, axis_out_tdest, axis_out_tuser,
             axis_out_tkeep, axis_out_tdata};
      if (areset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(axis_out_tvalid), 64'd1);
          chk("hold_stable", 64'(cur != held), 64'd0);
        end
        if (axis_out_tvalid && !axis_out_tready) begin
          chk("in_ready_blocked", 64'(axis_in_tready), 64'd0);
          held = cur;
          hold = 1'b1;
        end else begin
          hold = 1'b0;
        end
        if (axis_out_tvalid && axis_out_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(axis_out_tdata), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", 64'(axis_out_tdata), 64'(e[8*N-1:0]));
            chk("tkeep", 64'(axis_out_tkeep), 64'(e[8*N +: N]));
            chk("tuser", 64'(axis_out_tuser), 64'(e[9*N +: U]));
            chk("tdest", 64'(axis_out_tdest), 64'(e[9*N+U +: D]));
            chk("tid",   64'(axis_out_tid),   64'(e[9*N+U+D +: I]));
            chk("tlast", 64'(axis_out_tlast), 64'(e[EW-1]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send_beat(input logic [W-1:0] data, input logic last,
                           input logic [I-1:0] id, input logic [D-1:0] dest,
                           input logic [U-1:0] user, output int waits);
    logic acc;
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = data;
    axis_in_tlast  = last;
    axis_in_tid    = id;
    axis_in_tdest  = dest;
    axis_in_tuser  = user;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits <= 500) begin
      @(negedge aclk);
      acc = axis_in_tready;
      @(posedge aclk);
      #1;
      if (!acc) waits++;
    end
    if (acc) begin
      model_accept(data, last, id, dest, user);
    end else begin
      chk("accept_timeout", 64'(waits), 64'd0);
    end
    axis_in_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(axis_out_tvalid), 64'd0);
    chk("rst_tdata",  64'(axis_out_tdata),  64'd0);
    chk("rst_tkeep",  64'(axis_out_tkeep),  64'd0);
    chk("rst_tlast",  64'(axis_out_tlast),  64'd0);
    chk("rst_tid",    64'(axis_out_tid),    64'd0);
    areset = 1'b0;
    pk_beats.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int bound;
    logic [7:0] burst_byte;
    areset         = 1'b1;
    axis_in_tvalid = 1'b0;
    axis_in_tdata  = '0;
    axis_in_tlast  = 1'b0;
    axis_in_tid    = '0;
    axis_in_tdest  = '0;
    axis_in_tuser  = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_in_tready", 64'(axis_in_tready), 64'd1);
    do_reset();

    // Full word, then latency check.
    send_beat(8'h11, 1'b0, 4'd1, 2'd1, 1'b0, w);
    send_beat(8'h22, 1'b0, 4'd1, 2'd1, 1'b0, w);
    send_beat(8'h33, 1'b0, 4'd1, 2'd1, 1'b0, w);
    send_beat(8'h44, 1'b1, 4'd1, 2'd1, 1'b0, w);
    chk("latency_valid", 64'(axis_out_tvalid), 64'd1);

    // Short packet: two lanes.
    send_beat(8'hAA, 1'b0, 4'd2, 2'd2, 1'b0, w);
    send_beat(8'hBB, 1'b1, 4'd2, 2'd2, 1'b0, w);

    // Hold a full word with downstream stalled, then release.
    ready_pct = 0;
    @(posedge aclk);
    #1;
    for (int b = 0; b < S; b++) send_beat(8'h50 + 8'(b), 1'b0, 4'd6, 2'd3, 1'b0, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("stall_in_tready", 64'(axis_in_tready), 64'd0);
      @(posedge aclk);
      #1;
    end
    ready_pct       = 100;
    axis_out_tready = 1'b1;
    send_beat(8'h60, 1'b0, 4'd7, 2'd0, 1'b0, w);
    chk("release_accept_waits", 64'(w), 64'd0);
    send_beat(8'h61, 1'b0, 4'd7, 2'd0, 1'b0, w);
    send_beat(8'h62, 1'b0, 4'd7, 2'd0, 1'b0, w);
    send_beat(8'h63, 1'b0, 4'd7, 2'd0, 1'b0, w);

    // Continuous burst at full throughput.
    for (int b = 1; b <= 8; b++) begin
      burst_byte = 8'(b);
      send_beat(burst_byte, 1'b0, 4'd8, 2'd1, 1'b0, w);
      chk("burst_accept_waits", 64'(w), 64'd0);
    end

    // Reset mid-word discards the partial word.
    send_beat(8'hE0, 1'b0, 4'd9, 2'd2, 1'b0, w);
    send_beat(8'hE1, 1'b0, 4'd9, 2'd2, 1'b0, w);
    chk("pre_reset_queue", 64'(exp_q.size()), 64'd0);
    do_reset();
    for (int b = 0; b < S; b++) send_beat(8'hC0 + 8'(b), 1'b0, 4'd10, 2'd3, 1'b0, w);

    // Sideband: tid from first beat, tuser OR-ed.
    send_beat(8'h01, 1'b0, 4'd3, 2'd1, 1'b0, w);
    send_beat(8'h02, 1'b0, 4'd5, 2'd2, 1'b0, w);
    send_beat(8'h03, 1'b0, 4'd5, 2'd2, 1'b1, w);
    send_beat(8'h04, 1'b1, 4'd5, 2'd2, 1'b0, w);

    // Random traffic with backpressure and idle gaps.
    ready_pct = 70;
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge aclk);
        #1;
      end
      send_beat(8'($urandom), ($urandom_range(4) == 0), 4'($urandom), 2'($urandom),
                1'($urandom), w);
    end
    send_beat(8'h7E, 1'b1, 4'd0, 2'd0, 1'b0, w);

    // Drain.
    ready_pct = 100;
    bound = 0;
    while (exp_q.size() != 0 && bound < 100) begin
      @(posedge aclk);
      bound++;
    end
    repeat (2) @(posedge aclk);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
